// File: rtl/cc1200_tx_scheduler.sv
// Packet scheduler sharing the CC1200 radio link between the video word
// stream and the command/telemetry word source. Each burst is framed as two
// header words plus payload and streamed over a valid/ready handshake.
//
// Handshake: a word moves from this block to the SPI engine on every clock
// edge where TxValid and TxReady are both 1. TxValid is never withdrawn by
// this block while a header word waits for TxReady. Payload words pass
// straight through from the selected source, so they follow that source.
module cc1200_tx_scheduler #(
    parameter int PKT_WORDS  = 32,
    parameter int GAP_CYCLES = 64,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Enable,
    input  logic        TranEn,
    input  logic [11:0] TranData,
    input  logic [15:0] TranAdd,
    input  logic        TranFrame,
    output logic        NextData,
    input  logic        CmdReq,
    input  logic [11:0] CmdData,
    input  logic        CmdLast,
    output logic        CmdNext,
    input  logic        RadioRdy,
    input  logic        SpiBusy,
    output logic        PktStart,
    output logic [11:0] TxWord,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        TxLast,
    output logic        PktType,
    output logic        Timeout,
    output logic [15:0] PktCount,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_HDR0      = 3'd2,
        S_HDR1      = 3'd3,
        S_DATA      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_GAP       = 3'd6
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(PKT_WORDS - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_cmd_q;
    logic        pkt_type_q;
    logic        pkt_start_q;
    logic        tx_valid_q;
    logic        timeout_q;
    logic [7:0]  addr_lo_q;
    logic [15:0] pkt_count_q;
    logic [15:0] cnt_q;
    logic [7:0]  word_cnt_q;
    logic [11:0] tx_word_q;

    logic in_data;
    logic src_valid;
    logic word_last;
    logic data_hs;
    logic hdr_hs;
    logic pick_cmd;

    // Handshake qualifiers and arbitration decision for the current cycle
    always_comb begin
        in_data   = (state_q == S_DATA);
        src_valid = pkt_type_q ? CmdReq : TranEn;
        word_last = (word_cnt_q == LAST_IDX) | (pkt_type_q & CmdLast);
        data_hs   = in_data & src_valid & TxReady;
        hdr_hs    = tx_valid_q & TxReady;
        // Command wins a tie unless the previous packet was already a command
        pick_cmd  = CmdReq & (~TranEn | ~last_cmd_q);
    end

    // Output muxing: registered header words, pass-through payload words
    always_comb begin
        TxValid     = in_data ? src_valid : tx_valid_q;
        TxWord      = in_data ? (pkt_type_q ? CmdData : TranData) : tx_word_q;
        TxLast      = in_data & src_valid & word_last;
        NextData    = in_data & ~pkt_type_q & TranEn & TxReady;
        CmdNext     = in_data & pkt_type_q & CmdReq & TxReady;
        PktStart    = pkt_start_q;
        PktType     = pkt_type_q;
        Timeout     = timeout_q;
        PktCount    = pkt_count_q;
        dbg_state_o = state_q;
    end

    // Scheduler FSM with packet framing, counters and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_cmd_q  <= 1'b0;
            pkt_type_q  <= 1'b0;
            pkt_start_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            timeout_q   <= 1'b0;
            addr_lo_q   <= 8'h00;
            pkt_count_q <= 16'h0000;
            cnt_q       <= 16'h0000;
            word_cnt_q  <= 8'h00;
            tx_word_q   <= 12'h000;
        end else begin
            pkt_start_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Enable && (TranEn || CmdReq)) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    pkt_type_q  <= pick_cmd;
                    addr_lo_q   <= TranAdd[7:0];
                    word_cnt_q  <= 8'h00;
                    tx_word_q   <= pick_cmd ? {1'b1, 1'b0, 2'b00, pkt_count_q[15:8]}
                                            : {1'b0, TranFrame, 2'b00, TranAdd[15:8]};
                    tx_valid_q  <= 1'b1;
                    pkt_start_q <= 1'b1;
                    state_q     <= S_HDR0;
                end
                S_HDR0: begin
                    if (hdr_hs) begin
                        tx_word_q <= {4'h0, pkt_type_q ? pkt_count_q[7:0] : addr_lo_q};
                        state_q   <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (hdr_hs) begin
                        tx_valid_q <= 1'b0;
                        tx_word_q  <= 12'h000;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (data_hs) begin
                        word_cnt_q <= word_cnt_q + 8'd1;
                        if (word_last) begin
                            pkt_count_q <= pkt_count_q + 16'd1;
                            last_cmd_q  <= pkt_type_q;
                            cnt_q       <= 16'h0000;
                            state_q     <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!SpiBusy && RadioRdy) begin
                        cnt_q   <= 16'h0000;
                        state_q <= S_GAP;
                    end else if (cnt_q == TMO_LAST) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= 16'h0000;
                        state_q   <= S_GAP;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= 16'h0000;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc1200_tx_scheduler.sv
// Bench for cc1200_tx_scheduler: source models for the video and command
// streams, a scoreboard of expected transmit words, and scenario tasks.
module tb_cc1200_tx_scheduler;

    localparam int PKT_WORDS  = 32;
    localparam int GAP_CYCLES = 64;
    localparam int TIMEOUT    = 100;
    localparam int W          = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        Enable;
    logic        TranEn;
    logic [11:0] TranData;
    logic [15:0] TranAdd;
    logic        TranFrame;
    logic        NextData;
    logic        CmdReq;
    logic [11:0] CmdData;
    logic        CmdLast;
    logic        CmdNext;
    logic        RadioRdy;
    logic        SpiBusy;
    logic        PktStart;
    logic [11:0] TxWord;
    logic        TxValid;
    logic        TxReady;
    logic        TxLast;
    logic        PktType;
    logic        Timeout;
    logic [15:0] PktCount;
    logic [2:0]  dbg_state;

    cc1200_tx_scheduler #(
        .PKT_WORDS (PKT_WORDS),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (Enable),
        .TranEn     (TranEn),
        .TranData   (TranData),
        .TranAdd    (TranAdd),
        .TranFrame  (TranFrame),
        .NextData   (NextData),
        .CmdReq     (CmdReq),
        .CmdData    (CmdData),
        .CmdLast    (CmdLast),
        .CmdNext    (CmdNext),
        .RadioRdy   (RadioRdy),
        .SpiBusy    (SpiBusy),
        .PktStart   (PktStart),
        .TxWord     (TxWord),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .TxLast     (TxLast),
        .PktType    (PktType),
        .Timeout    (Timeout),
        .PktCount   (PktCount),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- source models ----------------
    int          vid_left  = 0;
    int          vid_seq   = 0;
    logic        vid_stall = 1'b0;
    logic [15:0] vid_addr  = 16'h0000;
    logic        vid_frame = 1'b0;
    logic [12:0] cmd_src_q[$];
    logic        pop_v_s = 1'b0;
    logic        pop_c_s = 1'b0;

    function automatic logic [11:0] vid_word(input int s);
        return 12'(s * 37 + 5);
    endfunction

    function automatic logic [11:0] cmd_val(input int i);
        return 12'(341 + i * 11);
    endfunction

    task automatic refresh_src();
        TranEn    = (vid_left > 0) && !vid_stall;
        TranData  = vid_word(vid_seq);
        TranAdd   = vid_addr;
        TranFrame = vid_frame;
        CmdReq    = (cmd_src_q.size() > 0);
        if (cmd_src_q.size() > 0) begin
            CmdData = cmd_src_q[0][11:0];
            CmdLast = cmd_src_q[0][12];
        end else begin
            CmdData = 12'h000;
            CmdLast = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        pop_v_s = NextData && !rst;
        pop_c_s = CmdNext && !rst;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_v_s && vid_left > 0) begin
                vid_left = vid_left - 1;
                vid_seq  = vid_seq + 1;
            end
            if (pop_c_s && cmd_src_q.size() > 0) void'(cmd_src_q.pop_front());
            pop_v_s = 1'b0;
            pop_c_s = 1'b0;
            refresh_src();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cmd_msg(input int base, input int len);
        for (int i = 0; i < len; i++) cmd_src_q.push_back({(i == len - 1), cmd_val(base + i)});
        refresh_src();
    endtask

    task automatic load_video(input int n, input logic [15:0] addr, input logic frame);
        vid_addr  = addr;
        vid_frame = frame;
        vid_left  = n;
        refresh_src();
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_pkt_cnt = 16'h0000;
    logic         type_q[$];
    int           start_edge_q[$];
    int           pkts_done = 0;
    int           nd_cnt    = 0;
    int           cn_cnt    = 0;
    int           tmo_cnt   = 0;
    int           last_edge = 0;

    task automatic push_video_pkt(input int base, input logic [15:0] addr, input logic frame);
        exp_q.push_back({1'b0, 1'b0, frame, 2'b00, addr[15:8]});
        exp_q.push_back({1'b0, 4'h0, addr[7:0]});
        for (int i = 0; i < PKT_WORDS; i++) exp_q.push_back({(i == PKT_WORDS - 1), vid_word(base + i)});
        exp_pkt_cnt = exp_pkt_cnt + 16'd1;
    endtask

    task automatic push_cmd_pkt(input int first, input int n);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_pkt_cnt[15:8]});
        exp_q.push_back({1'b0, 4'h0, exp_pkt_cnt[7:0]});
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), cmd_val(first + i)});
        exp_pkt_cnt = exp_pkt_cnt + 16'd1;
    endtask

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (!rst) begin
            if (TxValid && TxReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_word unexpected word got %h", {TxLast, TxWord});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({TxLast, TxWord} !== exp_w) begin
                        errors++;
                        $display("FAIL tx_word {last,word} got %h expected %h", {TxLast, TxWord}, exp_w);
                    end
                end
                if (TxLast) begin
                    pkts_done++;
                    last_edge = cyc + 1;
                end
            end
            if (NextData || CmdNext) begin
                checks++;
                if ((NextData && CmdNext) || (NextData && PktType) || (CmdNext && !PktType)) begin
                    errors++;
                    $display("FAIL pop_select NextData=%b CmdNext=%b PktType=%b", NextData, CmdNext, PktType);
                end
            end
            if (NextData) nd_cnt++;
            if (CmdNext) cn_cnt++;
            if (PktStart) begin
                type_q.push_back(PktType);
                start_edge_q.push_back(cyc);
            end
            if (Timeout) tmo_cnt++;
        end
    end

    task automatic wait_pkts(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pkts_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (pkts_done < target) begin
            errors++;
            $display("FAIL %s packets done got %0d expected %0d", name, pkts_done, target);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s words left in scoreboard got %0d expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({NextData, CmdNext, PktStart, TxValid, TxLast, Timeout, PktType} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0000000",
                     {NextData, CmdNext, PktStart, TxValid, TxLast, Timeout, PktType});
        end
        checks++;
        if (TxWord !== 12'h000) begin
            errors++;
            $display("FAIL reset_txword got %h expected 000", TxWord);
        end
        checks++;
        if (PktCount !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pktcount got %h expected 0000", PktCount);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_video();
        int load_cyc;
        int nd0;
        int p0;
        bit got;
        nd0 = nd_cnt;
        p0  = pkts_done;
        push_video_pkt(vid_seq, 16'h1234, 1'b1);
        load_video(PKT_WORDS, 16'h1234, 1'b1);
        load_cyc = cyc;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (PktStart) got = 1;
        end
        checks++;
        if (!got || (cyc - load_cyc) != 2 || TxValid !== 1'b1) begin
            errors++;
            $display("FAIL video_latency got start=%0b edges=%0d valid=%b expected 1 2 1", got, cyc - load_cyc, TxValid);
        end
        checks++;
        if (TxWord !== 12'h412) begin
            errors++;
            $display("FAIL video_hdr0 got %h expected 412", TxWord);
        end
        wait_pkts(p0 + 1, 200, "video");
        checks++;
        if (nd_cnt - nd0 != 32) begin
            errors++;
            $display("FAIL video_nextdata got %0d expected 32", nd_cnt - nd0);
        end
        checks++;
        if (PktCount !== 16'd1) begin
            errors++;
            $display("FAIL video_pktcount got %0d expected 1", PktCount);
        end
        check_drained("video");
    endtask

    task automatic test_back_to_back();
        int p0;
        int base;
        logic exp_types[4];
        exp_types[0] = 1'b1;
        exp_types[1] = 1'b0;
        exp_types[2] = 1'b1;
        exp_types[3] = 1'b0;
        p0 = pkts_done;
        type_q.delete();
        start_edge_q.delete();
        base = vid_seq;
        push_cmd_pkt(0, 4);
        push_video_pkt(base, 16'h0F0F, 1'b0);
        push_cmd_pkt(4, 4);
        push_video_pkt(base + PKT_WORDS, 16'h0F0F, 1'b0);
        load_cmd_msg(0, 4);
        load_cmd_msg(4, 4);
        load_video(2 * PKT_WORDS, 16'h0F0F, 1'b0);
        wait_pkts(p0 + 4, 1000, "alternate");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (type_q.size() <= i || type_q[i] !== exp_types[i]) begin
                errors++;
                $display("FAIL alternate_type pkt %0d got %b expected %b", i,
                         (type_q.size() > i) ? type_q[i] : 1'bx, exp_types[i]);
            end
        end
        checks++;
        if (start_edge_q.size() < 2 || start_edge_q[1] - start_edge_q[0] != 4 + 69) begin
            errors++;
            $display("FAIL alternate_occupancy got %0d expected 73",
                     (start_edge_q.size() >= 2) ? start_edge_q[1] - start_edge_q[0] : -1);
        end
        check_drained("alternate");
    endtask

    task automatic test_cmd_truncation();
        int p0;
        int cn0;
        p0  = pkts_done;
        cn0 = cn_cnt;
        push_cmd_pkt(100, 32);
        push_cmd_pkt(132, 8);
        load_cmd_msg(100, 40);
        wait_pkts(p0 + 2, 600, "truncation");
        checks++;
        if (cn_cnt - cn0 != 40) begin
            errors++;
            $display("FAIL truncation_cmdnext got %0d expected 40", cn_cnt - cn0);
        end
        check_drained("truncation");
    endtask

    task automatic test_timeout();
        int p0;
        int t0;
        int te;
        int se;
        bit got;
        repeat (GAP_CYCLES + 8) tick();
        p0 = pkts_done;
        t0 = tmo_cnt;
        RadioRdy = 1'b0;
        push_cmd_pkt(200, 2);
        push_cmd_pkt(202, 1);
        load_cmd_msg(200, 2);
        load_cmd_msg(202, 1);
        wait_pkts(p0 + 1, 100, "timeout_first");
        got = 0;
        te  = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (Timeout) begin
                got = 1;
                te  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!got || te - last_edge != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_delay got seen=%0b cycles=%0d expected 1 %0d", got, te - last_edge, TIMEOUT);
        end
        tick();
        RadioRdy = 1'b1;
        got = 0;
        se  = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (PktStart) begin
                got = 1;
                se  = cyc;
            end
        end
        checks++;
        if (!got || se - te != GAP_CYCLES + 2) begin
            errors++;
            $display("FAIL timeout_gap got seen=%0b cycles=%0d expected 1 %0d", got, se - te, GAP_CYCLES + 2);
        end
        wait_pkts(p0 + 2, 100, "timeout_second");
        repeat (GAP_CYCLES + 8) tick();
        checks++;
        if (tmo_cnt - t0 != 1) begin
            errors++;
            $display("FAIL timeout_pulses got %0d expected 1", tmo_cnt - t0);
        end
        check_drained("timeout");
    endtask

    task automatic test_stall();
        int p0;
        int nd0;
        int n;
        bit got;
        p0  = pkts_done;
        nd0 = nd_cnt;
        push_video_pkt(vid_seq, 16'hABCD, 1'b0);
        load_video(PKT_WORDS, 16'hABCD, 1'b0);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (PktStart) got = 1;
        end
        tick();
        TxReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (TxValid !== 1'b1 || TxWord !== 12'h0CD || TxLast !== 1'b0) begin
                errors++;
                $display("FAIL hdr1_hold got valid=%b word=%h last=%b expected 1 0cd 0", TxValid, TxWord, TxLast);
            end
            tick();
        end
        TxReady = 1'b1;
        n = 0;
        while (nd_cnt - nd0 < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        vid_stall = 1'b1;
        refresh_src();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (NextData !== 1'b0 || TxValid !== 1'b0) begin
                errors++;
                $display("FAIL stall_quiet got nextdata=%b valid=%b expected 0 0", NextData, TxValid);
            end
            tick();
        end
        vid_stall = 1'b0;
        refresh_src();
        wait_pkts(p0 + 1, 200, "stall");
        checks++;
        if (nd_cnt - nd0 != 32) begin
            errors++;
            $display("FAIL stall_nextdata got %0d expected 32", nd_cnt - nd0);
        end
        check_drained("stall");
    endtask

    task automatic test_reset_mid_packet();
        int nd0;
        int n;
        int p0;
        repeat (GAP_CYCLES + 8) tick();
        nd0 = nd_cnt;
        push_video_pkt(vid_seq, 16'h5678, 1'b1);
        load_video(PKT_WORDS, 16'h5678, 1'b1);
        n = 0;
        while (nd_cnt - nd0 < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        rst      = 1'b1;
        vid_left = 0;
        refresh_src();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({NextData, CmdNext, PktStart, TxValid, TxLast, Timeout, PktType} !== 7'b0 || TxWord !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs got ctrl=%b word=%h expected 0000000 000",
                     {NextData, CmdNext, PktStart, TxValid, TxLast, Timeout, PktType}, TxWord);
        end
        checks++;
        if (PktCount !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_pktcount got %h expected 0000", PktCount);
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_pkt_cnt = 16'h0000;
        vid_seq     = 0;
        refresh_src();
        tick();
        p0 = pkts_done;
        push_video_pkt(vid_seq, 16'h5678, 1'b1);
        load_video(PKT_WORDS, 16'h5678, 1'b1);
        wait_pkts(p0 + 1, 200, "midreset_restart");
        checks++;
        if (PktCount !== 16'd1) begin
            errors++;
            $display("FAIL midreset_restart_count got %0d expected 1", PktCount);
        end
        check_drained("midreset");
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst       = 1'b1;
        Enable    = 1'b1;
        RadioRdy  = 1'b1;
        SpiBusy   = 1'b0;
        TxReady   = 1'b1;
        refresh_src();
        test_reset();
        test_video();
        test_back_to_back();
        test_cmd_truncation();
        test_timeout();
        test_stall();
        test_reset_mid_packet();
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
